// File: rtl/uart_tx_param_if.sv
// Producer-side handshake and serial line of the parametrised UART transmitter.
interface uart_tx_param_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] data;
   logic              flag_start;
   logic              out;
   logic              flag_busy;
   logic              flag_done;

   modport master (output data, flag_start, input out, flag_busy, flag_done);
   modport slave  (input data, flag_start, output out, flag_busy, flag_done);
endinterface

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start, LSB-first data, optional parity, 1-2 stop bits.
// Zero-latency accept (out drops on the accept edge); flag_start while busy is ignored, never queued.
module uart_tx_param #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 1,
   parameter int PARITY       = 1,
   parameter int STOP_BITS    = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   uart_tx_param_if.slave tx
);

   if (PARITY < 0 || PARITY > 2 || (STOP_BITS != 1 && STOP_BITS != 2) ||
       CLKS_PER_BIT < 1 || DATA_W < 5 || DATA_W > 16) begin : g_bad_param
      $error("uart_tx_param: illegal parameter combination");
   end

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IDX_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
   localparam logic             SIDX_LAST = 1'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      PAR   = 3'd3,
      STOP  = 3'd4
   } state_t;

   state_t            state, state_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic [IDX_W-1:0]  idx, idx_n;
   logic              sidx, sidx_n;
   logic [DATA_W-1:0] shreg, shreg_n;
   logic              par_bit, par_bit_n;
   logic              out_r, out_n;
   logic              busy_r, busy_n;
   logic              done_r, done_n;
   logic              bit_end;

   assign bit_end = (cnt == CNT_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         idx     <= '0;
         sidx    <= 1'b0;
         shreg   <= '0;
         par_bit <= 1'b0;
         out_r   <= 1'b1;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         idx     <= idx_n;
         sidx    <= sidx_n;
         shreg   <= shreg_n;
         par_bit <= par_bit_n;
         out_r   <= out_n;
         busy_r  <= busy_n;
         done_r  <= done_n;
      end
   end

   // out is computed one bit ahead so it changes on the same edge as the state.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      idx_n     = idx;
      sidx_n    = sidx;
      shreg_n   = shreg;
      par_bit_n = par_bit;
      out_n     = out_r;
      busy_n    = busy_r;
      done_n    = 1'b0;

      if (state != IDLE) begin
         cnt_n = bit_end ? '0 : cnt + CNT_W'(1);
      end

      case (state)
         IDLE: begin
            if (tx.flag_start) begin
               state_n   = START;
               shreg_n   = tx.data;
               par_bit_n = (PARITY == 2) ? ~^tx.data : ^tx.data;
               cnt_n     = '0;
               out_n     = 1'b0;
               busy_n    = 1'b1;
            end
         end
         START: begin
            if (bit_end) begin
               state_n = DATA;
               idx_n   = '0;
               out_n   = shreg[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               if (idx == IDX_LAST) begin
                  if (PARITY != 0) begin
                     state_n = PAR;
                     out_n   = par_bit;
                  end else begin
                     state_n = STOP;
                     sidx_n  = 1'b0;
                     out_n   = 1'b1;
                  end
               end else begin
                  idx_n   = idx + IDX_W'(1);
                  shreg_n = shreg >> 1;
                  out_n   = shreg[1];
               end
            end
         end
         PAR: begin
            if (bit_end) begin
               state_n = STOP;
               sidx_n  = 1'b0;
               out_n   = 1'b1;
            end
         end
         STOP: begin
            if (bit_end) begin
               if (sidx == SIDX_LAST) begin
                  state_n = IDLE;
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
               end else begin
                  sidx_n = 1'b1;
               end
               out_n = 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            out_n   = 1'b1;
            busy_n  = 1'b0;
         end
      endcase
   end

   assign tx.out       = out_r;
   assign tx.flag_busy = busy_r;
   assign tx.flag_done = done_r;

endmodule

// File: tb/tb_uart_tx_param.sv
// Four transmitter configurations checked cycle by cycle against a frame-level reference model.
module tb_uart_tx_param;

   localparam int NI = 4;
   localparam int DW  [NI] = '{8, 8, 7, 8};
   localparam int CPB [NI] = '{4, 1, 2, 2};
   localparam int PAR [NI] = '{1, 2, 0, 1};
   localparam int SB  [NI] = '{1, 2, 1, 1};

   logic        clk;
   logic        rst_n;
   logic        start_s [NI];
   logic [15:0] data_s  [NI];
   logic        out_o   [NI];
   logic        busy_o  [NI];
   logic        done_o  [NI];

   int checks = 0;
   int fails  = 0;

   uart_tx_param_if #(.DATA_W(8)) if_a ();
   uart_tx_param_if #(.DATA_W(8)) if_b ();
   uart_tx_param_if #(.DATA_W(7)) if_c ();
   uart_tx_param_if #(.DATA_W(8)) if_d ();

   uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1))
      dut_a (.clk(clk), .rst_n(rst_n), .tx(if_a));
   uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY(2), .STOP_BITS(2))
      dut_b (.clk(clk), .rst_n(rst_n), .tx(if_b));
   uart_tx_param #(.DATA_W(7), .CLKS_PER_BIT(2), .PARITY(0), .STOP_BITS(1))
      dut_c (.clk(clk), .rst_n(rst_n), .tx(if_c));
   uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(2), .PARITY(1), .STOP_BITS(1))
      dut_d (.clk(clk), .rst_n(rst_n), .tx(if_d));

   assign if_a.data = data_s[0][7:0];  assign if_a.flag_start = start_s[0];
   assign if_b.data = data_s[1][7:0];  assign if_b.flag_start = start_s[1];
   assign if_c.data = data_s[2][6:0];  assign if_c.flag_start = start_s[2];
   assign if_d.data = data_s[3][7:0];  assign if_d.flag_start = start_s[3];

   assign out_o[0] = if_a.out;  assign busy_o[0] = if_a.flag_busy;  assign done_o[0] = if_a.flag_done;
   assign out_o[1] = if_b.out;  assign busy_o[1] = if_b.flag_busy;  assign done_o[1] = if_b.flag_done;
   assign out_o[2] = if_c.out;  assign busy_o[2] = if_c.flag_busy;  assign done_o[2] = if_c.flag_done;
   assign out_o[3] = if_d.out;  assign busy_o[3] = if_d.flag_busy;  assign done_o[3] = if_d.flag_done;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int flen(input int i);
      return 1 + DW[i] + ((PAR[i] != 0) ? 1 : 0) + SB[i];
   endfunction

   // Bit k of the frame for word w: start, data LSB first, optional parity, stop bits.
   function automatic logic frame_bit(input int i, input logic [15:0] w, input int k);
      logic [15:0] m;
      m = w & ((16'h1 << DW[i]) - 16'h1);
      if (k == 0) return 1'b0;
      if (k <= DW[i]) return m[k-1];
      if (PAR[i] != 0 && k == DW[i] + 1) return (PAR[i] == 1) ? ^m : ~^m;
      return 1'b1;
   endfunction

   logic        m_act  [NI];
   int          m_cyc  [NI];
   logic        m_done [NI];
   logic [15:0] m_word [NI];

   always @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < NI; i++) begin
         if (!rst_n) begin
            m_act[i]  = 1'b0;
            m_cyc[i]  = 0;
            m_done[i] = 1'b0;
         end else begin
            m_done[i] = 1'b0;
            if (m_act[i]) begin
               m_cyc[i]++;
               if (m_cyc[i] == flen(i) * CPB[i]) begin
                  m_act[i]  = 1'b0;
                  m_done[i] = 1'b1;
               end
            end else if (start_s[i]) begin
               m_act[i]  = 1'b1;
               m_cyc[i]  = 0;
               m_word[i] = data_s[i];
            end
         end
      end
   end

   int run_len  [NI];
   int idle_len [NI];
   int busy_len [NI];
   int gap_len  [NI];
   int dcnt     [NI];

   initial begin
      for (int i = 0; i < NI; i++) begin
         run_len[i] = 0; idle_len[i] = 0; busy_len[i] = 0; gap_len[i] = 0; dcnt[i] = 0;
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < NI; i++) begin
         check($sformatf("out%0d", i), out_o[i],
               m_act[i] ? frame_bit(i, m_word[i], m_cyc[i] / CPB[i]) : 1'b1);
         check($sformatf("busy%0d", i), busy_o[i], m_act[i]);
         check($sformatf("done%0d", i), done_o[i], m_done[i]);
         if (busy_o[i]) begin
            if (run_len[i] == 0) gap_len[i] = idle_len[i];
            run_len[i]++;
            idle_len[i] = 0;
         end else begin
            if (run_len[i] != 0) busy_len[i] = run_len[i];
            run_len[i] = 0;
            idle_len[i]++;
         end
         if (done_o[i]) dcnt[i]++;
      end
   end

   task automatic wait_busy(input int i, input logic v, input int budget);
      int n;
      n = 0;
      while (busy_o[i] !== v && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      check($sformatf("wait_busy%0d_%0d", i, v), busy_o[i] === v, 1'b1);
   endtask

   task automatic send(input int i, input logic [15:0] w);
      data_s[i]  = w;
      start_s[i] = 1'b1;
      @(posedge clk); #1;
      start_s[i] = 1'b0;
      wait_busy(i, 1'b0, 200);
   endtask

   task automatic back_to_back();
      data_s[3]  = 16'h3C;
      start_s[3] = 1'b1;
      @(posedge clk); #1;
      repeat (8) @(posedge clk);
      #1 data_s[3] = 16'hC3;
      wait_busy(3, 1'b0, 60);
      wait_busy(3, 1'b1, 4);
      start_s[3] = 1'b0;
      wait_busy(3, 1'b0, 60);
   endtask

   int base [NI];

   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < NI; i++) begin
         start_s[i] = 1'b0;
         data_s[i]  = 16'h0;
      end
      repeat (10) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) check($sformatf("idle_out%0d", i), out_o[i], 1'b1);

      for (int i = 0; i < NI; i++) base[i] = dcnt[i];
      fork
         send(0, 16'hA5);
         send(1, 16'h00);
         send(2, 16'h7F);
         back_to_back();
      join
      repeat (3) @(posedge clk);
      #1;
      check("len_a", busy_len[0], 44);
      check("len_b", busy_len[1], 12);
      check("len_c", busy_len[2], 18);
      check("len_d", busy_len[3], 22);
      check("gap_d", gap_len[3], 1);
      check("dones_a", dcnt[0] - base[0], 1);
      check("dones_b", dcnt[1] - base[1], 1);
      check("dones_c", dcnt[2] - base[2], 1);
      check("dones_d", dcnt[3] - base[3], 2);

      // Abort a frame during its data bits; outputs must return to idle without a clock edge.
      data_s[0]  = 16'hA5;
      start_s[0] = 1'b1;
      @(posedge clk); #1;
      start_s[0] = 1'b0;
      repeat (12) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_out", out_o[0], 1'b1);
      check("rst_busy", busy_o[0], 1'b0);
      check("rst_done", done_o[0], 1'b0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      base[0] = dcnt[0];
      send(0, 16'hA5);
      repeat (2) @(posedge clk);
      #1;
      check("post_rst_len", busy_len[0], 44);
      check("post_rst_done", dcnt[0] - base[0], 1);

      repeat (800) begin
         @(posedge clk); #1;
         for (int i = 0; i < NI; i++) begin
            start_s[i] = ($urandom_range(0, 3) == 0);
            data_s[i]  = 16'($urandom);
         end
      end
      for (int i = 0; i < NI; i++) start_s[i] = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) check($sformatf("drain_busy%0d", i), busy_o[i], 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter that serialises one DATA_W-bit word per request.
- Configurable baud divider, parity mode (none/even/odd) and stop-bit count.
- Start/busy handshake toward the producer.
- Sits between a byte/word source (FIFO, command logic) and the board TX pin.
- Successor of the fixed 8-bit, 1-clock-per-bit, even-parity transmitter.

Parameters:
DATA_W, 8, data bits per frame (5..16).
CLKS_PER_BIT, 1, clk cycles per serial bit (>=1); baud = f_clk / CLKS_PER_BIT.
PARITY, 1, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
data  input  DATA_W  word to send, sampled only on the accept cycle
flag_start  input  1  request; accepted when flag_start=1 and flag_busy=0 at a rising edge
out  output  1  serial line, idle high
flag_busy  output  1  high while a frame is in progress
flag_done  output  1  one-cycle pulse when the final stop bit completes

Behaviour:
- Reset (async, rst_n=0): out=1, flag_busy=0, flag_done=0; state=IDLE; all counters=0. Reset mid-frame aborts immediately, with no partial stop bit.
- Frame order on out: start(0), data[0]..data[DATA_W-1] (LSB first), parity (if PARITY!=0), STOP_BITS x stop(1).
  - Parity bit = ^data for even, ~^data for odd, computed on the latched word.
- Each bit drives out for exactly CLKS_PER_BIT cycles.
- Frame length: N = 1 + DATA_W + (PARITY!=0) + STOP_BITS bits; CLKS_PER_BIT*N cycles.
- Accept edge (IDLE, flag_start=1):
  - data latched into shift register;
  - out<=0 and flag_busy<=1 at that same edge (zero latency);
  - bit-cycle counter cleared.
- States: IDLE -> START -> DATA -> PARITY (skipped if PARITY=0) -> STOP -> IDLE.
  - Bit-cycle counter counts 0..CLKS_PER_BIT-1; bit advances when counter = CLKS_PER_BIT-1.
  - DATA bit index counts 0..DATA_W-1; STOP index counts 0..STOP_BITS-1.
  - Counter widths are $clog2-sized; no wrap is observable.
- End of frame: at the edge ending the last stop bit:
  - flag_busy<=0, flag_done<=1 for exactly one cycle, out stays 1.
- Back-to-back: flag_start held high is re-accepted on the first edge where flag_busy=0. This gives exactly one idle-high cycle between frames (inter-frame gap = 1 clk).
- flag_start while busy: ignored and not queued. Changes on data while busy do not affect the frame in flight.
- CLKS_PER_BIT=1: one bit per clk, same ordering and handshake.
- Illegal parameters (PARITY>2, STOP_BITS not 1/2, CLKS_PER_BIT=0): elaboration-time error.

Test Plan:
- Reset idle: hold rst_n=0 10 cycles, then release with flag_start=0 -> out=1, flag_busy=0, flag_done=0 indefinitely.
- Basic frame (DATA_W=8, CLKS_PER_BIT=4, PARITY=1, STOP_BITS=1), data=0xA5 pulsed 1 cycle:
  - out sequence, each held 4 clk: 0,1,0,1,0,0,1,0,1,0(parity),1;
  - flag_busy high exactly 44 cycles, then flag_done one pulse.
- Odd parity and 2 stop bits (PARITY=2, STOP_BITS=2, CLKS_PER_BIT=1), data=0x00:
  - out = 0, 0x8 zeros, 1(parity), 1, 1;
  - busy for 12 cycles.
- No parity, DATA_W=7, data=7'h7F:
  - out = 0, 1x7, 1(stop);
  - busy for 9*CLKS_PER_BIT cycles; no parity slot present.
- Back-to-back and ignore (CLKS_PER_BIT=2):
  - hold flag_start=1 with data 0x3C, change data to 0xC3 mid-frame;
  - first frame carries 0x3C; second frame (0xC3) starts after exactly one idle cycle; flag_done pulses once per frame.
- Reset mid-frame: assert rst_n=0 during the DATA state of the 0xA5 frame -> out=1 and flag_busy=0 asynchronously (before the next edge); after release the next request sends a complete, correct frame.
